// File: rtl/axi_bus_arbiter_pkg.sv
// Shared types and constants for the two-master AXI read/write arbiter.
package axi_arb_pkg;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
    typedef enum logic {MST_M0 = 1'b0, MST_M1 = 1'b1} mst_sel_t;

    localparam logic [3:0] AXI_M0_ID = 4'd0;
    localparam logic [3:0] AXI_M1_ID = 4'd1;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [2:0] AXI_SIZE_1B = 3'd0;
    localparam logic [2:0] AXI_SIZE_2B = 3'd1;
    localparam logic [2:0] AXI_SIZE_4B = 3'd2;

    function automatic mst_sel_t other_mst(input mst_sel_t m);
        return (m == MST_M0) ? MST_M1 : MST_M0;
    endfunction

endpackage

// File: rtl/axi_bus_arbiter_if.sv
// One AXI3-style port (AR/R/AW/W/B) with master and slave views.
interface axi_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4
) ();

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [3:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [1:0]          arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [1:0]          awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;

    logic [ID_W-1:0]     wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_bus_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the master not granted last time wins.
module axi_rr_arb2
    import axi_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  mst_sel_t   rr_last_i,
    output logic       gnt_valid_o,
    output mst_sel_t   gnt_o
);

    always_comb begin
        gnt_valid_o = |req_i;
        gnt_o       = MST_M0;
        case (req_i)
            2'b01:   gnt_o = MST_M0;
            2'b10:   gnt_o = MST_M1;
            2'b11:   gnt_o = other_mst(rr_last_i);
            default: gnt_o = MST_M0;
        endcase
    end

endmodule

// File: rtl/axi_bus_arbiter.sv
// Shares one AXI master port between icache (M0, read-only) and dcache (M1, read/write).
module axi_bus_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned     ADDR_W = 32,
    parameter int unsigned     DATA_W = 32,
    parameter int unsigned     ID_W   = 4,
    parameter logic [ID_W-1:0] M0_ID  = ID_W'(AXI_M0_ID),
    parameter logic [ID_W-1:0] M1_ID  = ID_W'(AXI_M1_ID)
) (
    input logic               aclk,
    input logic               aresetn,
    axi_bus_arbiter_if.slave  m0,
    axi_bus_arbiter_if.slave  m1,
    axi_bus_arbiter_if.master axi
);

    rd_state_t rd_state_q, rd_state_d;
    wr_state_t wr_state_q, wr_state_d;
    mst_sel_t  grant_q, grant_d;
    mst_sel_t  rr_last_q, rr_last_d;

    logic              wr_busy;
    logic [1:0]        arb_req;
    logic              arb_gnt_valid;
    mst_sel_t          arb_gnt;
    logic [ADDR_W-1:0] ar_addr;
    logic [DATA_W-1:0] r_data;
    logic              unused_inputs;

    assign wr_busy = (wr_state_q != W_IDLE);
    // A fresh M1 read waits for any in-flight M1 write so it cannot overtake it.
    assign arb_req = {m1.arvalid & ~wr_busy, m0.arvalid};

    axi_rr_arb2 u_rr_arb (
        .req_i       (arb_req),
        .rr_last_i   (rr_last_q),
        .gnt_valid_o (arb_gnt_valid),
        .gnt_o       (arb_gnt)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state_q <= R_IDLE;
            wr_state_q <= W_IDLE;
            grant_q    <= MST_M0;
            rr_last_q  <= MST_M1;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            grant_q    <= grant_d;
            rr_last_q  <= rr_last_d;
        end
    end

    // Read path: AR mux from the granted master, R routed back to it alone.
    always_comb begin
        rd_state_d  = rd_state_q;
        grant_d     = grant_q;
        rr_last_d   = rr_last_q;

        ar_addr     = (grant_q == MST_M1) ? m1.araddr : m0.araddr;
        r_data      = axi.rdata;

        axi.arid    = (grant_q == MST_M1) ? M1_ID : M0_ID;
        axi.araddr  = ar_addr;
        axi.arlen   = (grant_q == MST_M1) ? m1.arlen : m0.arlen;
        axi.arsize  = (grant_q == MST_M1) ? m1.arsize : m0.arsize;
        axi.arburst = (grant_q == MST_M1) ? m1.arburst : m0.arburst;
        axi.arlock  = 2'b00;
        axi.arcache = 4'b0000;
        axi.arprot  = 3'b000;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;

        m0.arready  = 1'b0;
        m1.arready  = 1'b0;
        m0.rvalid   = 1'b0;
        m1.rvalid   = 1'b0;
        m0.rid      = axi.rid;
        m1.rid      = axi.rid;
        m0.rdata    = r_data;
        m1.rdata    = r_data;
        m0.rresp    = axi.rresp;
        m1.rresp    = axi.rresp;
        m0.rlast    = axi.rlast;
        m1.rlast    = axi.rlast;

        case (rd_state_q)
            R_IDLE: begin
                if (arb_gnt_valid) begin
                    grant_d    = arb_gnt;
                    rd_state_d = R_AR;
                end
            end
            R_AR: begin
                axi.arvalid = 1'b1;
                if (grant_q == MST_M1) m1.arready = axi.arready;
                else                   m0.arready = axi.arready;
                if (axi.arready) begin
                    rr_last_d  = grant_q;
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (grant_q == MST_M1) begin
                    m1.rvalid  = axi.rvalid;
                    axi.rready = m1.rready;
                end else begin
                    m0.rvalid  = axi.rvalid;
                    axi.rready = m0.rready;
                end
                if (axi.rvalid && axi.rready && axi.rlast) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Write path: M1 only, each channel opened in its own phase.
    always_comb begin
        wr_state_d  = wr_state_q;

        axi.awid    = M1_ID;
        axi.awaddr  = m1.awaddr;
        axi.awlen   = m1.awlen;
        axi.awsize  = m1.awsize;
        axi.awburst = m1.awburst;
        axi.awlock  = 2'b00;
        axi.awcache = 4'b0000;
        axi.awprot  = 3'b000;
        axi.awvalid = 1'b0;
        axi.wid     = M1_ID;
        axi.wdata   = m1.wdata;
        axi.wstrb   = m1.wstrb;
        axi.wlast   = m1.wlast;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;

        m1.awready  = 1'b0;
        m1.wready   = 1'b0;
        m1.bid      = axi.bid;
        m1.bresp    = axi.bresp;
        m1.bvalid   = 1'b0;

        m0.awready  = 1'b0;
        m0.wready   = 1'b0;
        m0.bid      = '0;
        m0.bresp    = 2'b00;
        m0.bvalid   = 1'b0;

        case (wr_state_q)
            W_IDLE: begin
                if (m1.awvalid) wr_state_d = W_ADDR;
            end
            W_ADDR: begin
                axi.awvalid = m1.awvalid;
                m1.awready  = axi.awready;
                if (m1.awvalid && axi.awready) wr_state_d = W_DATA;
            end
            W_DATA: begin
                axi.wvalid = m1.wvalid;
                m1.wready  = axi.wready;
                if (m1.wvalid && axi.wready && m1.wlast) wr_state_d = W_RESP;
            end
            W_RESP: begin
                m1.bvalid  = axi.bvalid;
                axi.bready = m1.bready;
                if (axi.bvalid && m1.bready) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    assign unused_inputs = ^{m0.arid, m0.arlock, m0.arcache, m0.arprot,
                             m0.awid, m0.awaddr, m0.awlen, m0.awsize, m0.awburst,
                             m0.awlock, m0.awcache, m0.awprot, m0.awvalid,
                             m0.wid, m0.wdata, m0.wstrb, m0.wlast, m0.wvalid, m0.bready,
                             m1.arid, m1.arlock, m1.arcache, m1.arprot,
                             m1.awid, m1.awlock, m1.awcache, m1.awprot, m1.wid};

endmodule

// File: tb/tb_axi_bus_arbiter.sv
// Directed bench for axi_bus_arbiter: routing, round-robin, RAW stall, AR stall, async reset.
module tb_axi_bus_arbiter;
    import axi_arb_pkg::*;

    logic aclk;
    logic aresetn;
    int   tests_run;
    int   tests_failed;

    axi_bus_arbiter_if m0_if ();
    axi_bus_arbiter_if m1_if ();
    axi_bus_arbiter_if axi_if ();

    axi_bus_arbiter dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .m0      (m0_if),
        .m1      (m1_if),
        .axi     (axi_if)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic init_inputs();
        m0_if.arid = '0; m0_if.araddr = '0; m0_if.arlen = '0; m0_if.arsize = AXI_SIZE_4B;
        m0_if.arburst = AXI_BURST_INCR; m0_if.arlock = '0; m0_if.arcache = '0;
        m0_if.arprot = '0; m0_if.arvalid = 0; m0_if.rready = 1;
        m0_if.awid = '0; m0_if.awaddr = '0; m0_if.awlen = '0; m0_if.awsize = '0;
        m0_if.awburst = '0; m0_if.awlock = '0; m0_if.awcache = '0; m0_if.awprot = '0;
        m0_if.awvalid = 0; m0_if.wid = '0; m0_if.wdata = '0; m0_if.wstrb = '0;
        m0_if.wlast = 0; m0_if.wvalid = 0; m0_if.bready = 0;
        m1_if.arid = '0; m1_if.araddr = '0; m1_if.arlen = '0; m1_if.arsize = AXI_SIZE_4B;
        m1_if.arburst = AXI_BURST_INCR; m1_if.arlock = '0; m1_if.arcache = '0;
        m1_if.arprot = '0; m1_if.arvalid = 0; m1_if.rready = 1;
        m1_if.awid = '0; m1_if.awaddr = '0; m1_if.awlen = '0; m1_if.awsize = AXI_SIZE_4B;
        m1_if.awburst = AXI_BURST_INCR; m1_if.awlock = '0; m1_if.awcache = '0;
        m1_if.awprot = '0; m1_if.awvalid = 0; m1_if.wid = '0; m1_if.wdata = '0;
        m1_if.wstrb = '0; m1_if.wlast = 0; m1_if.wvalid = 0; m1_if.bready = 0;
        axi_if.arready = 0; axi_if.rid = '0; axi_if.rdata = '0; axi_if.rresp = '0;
        axi_if.rlast = 0; axi_if.rvalid = 0; axi_if.awready = 0; axi_if.wready = 0;
        axi_if.bid = '0; axi_if.bresp = '0; axi_if.bvalid = 0;
    endtask

    task automatic apply_reset();
        aresetn = 1'b0;
        cyc();
        cyc();
        aresetn = 1'b1;
        cyc();
    endtask

    task automatic wait_arvalid(output bit seen);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (axi_if.arvalid === 1'b1) begin
                seen = 1;
                break;
            end
            cyc();
        end
    endtask

    task automatic ar_handshake();
        axi_if.arready = 1'b1;
        cyc();
        axi_if.arready = 1'b0;
    endtask

    // Drives R beats and counts beats that did not reach exactly the intended master.
    task automatic run_r_burst(input int beats, input bit to_m1, input bit with_last,
                               output int bad);
        logic [31:0] exp_data;
        logic        exp_last;
        bad = 0;
        for (int i = 0; i < beats; i++) begin
            exp_data = 32'hd000_0000 + 32'(i);
            exp_last = with_last && (i == beats - 1);
            axi_if.rvalid = 1'b1;
            axi_if.rdata  = exp_data;
            axi_if.rlast  = exp_last;
            axi_if.rresp  = 2'b00;
            #1;
            if (to_m1) begin
                if (!(m1_if.rvalid === 1'b1 && m1_if.rdata === exp_data &&
                      m1_if.rlast === exp_last && m0_if.rvalid === 1'b0 &&
                      axi_if.rready === 1'b1)) bad++;
            end else begin
                if (!(m0_if.rvalid === 1'b1 && m0_if.rdata === exp_data &&
                      m0_if.rlast === exp_last && m1_if.rvalid === 1'b0 &&
                      axi_if.rready === 1'b1)) bad++;
            end
            cyc();
        end
        axi_if.rvalid = 1'b0;
        axi_if.rlast  = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] vld;
        logic [17:0] side;
        init_inputs();
        aresetn = 1'b0;
        m0_if.arvalid = 1'b1;
        m1_if.awvalid = 1'b1;
        #3;
        cyc();
        cyc();
        vld = {axi_if.arvalid, axi_if.awvalid, axi_if.wvalid, axi_if.rready, axi_if.bready,
               m0_if.arready, m0_if.rvalid, m1_if.arready, m1_if.rvalid, m1_if.awready,
               m1_if.wready, m1_if.bvalid};
        tests_run++;
        if (vld !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_valids: got %h expected 000", vld);
        end
        side = {axi_if.arlock, axi_if.arcache, axi_if.arprot,
                axi_if.awlock, axi_if.awcache, axi_if.awprot};
        tests_run++;
        if (side !== 18'h0) begin
            tests_failed++;
            $display("FAIL reset_sideband: got %h expected 0", side);
        end
        tests_run++;
        if (dut.rd_state_q !== R_IDLE || dut.wr_state_q !== W_IDLE || dut.rr_last_q !== MST_M1)
        begin
            tests_failed++;
            $display("FAIL reset_state: got rd=%0d wr=%0d rr=%0d expected 0 0 1",
                     dut.rd_state_q, dut.wr_state_q, dut.rr_last_q);
        end
        m0_if.arvalid = 1'b0;
        m1_if.awvalid = 1'b0;
        aresetn = 1'b1;
        cyc();
    endtask

    task automatic test_m0_single();
        bit seen;
        int bad;
        apply_reset();
        m0_if.araddr = 32'hbfc0_0000;
        m0_if.arlen = 4'd7;
        m0_if.arvalid = 1'b1;
        wait_arvalid(seen);
        tests_run++;
        if (!seen || {axi_if.arid, axi_if.araddr, axi_if.arlen} !== {4'd0, 32'hbfc0_0000, 4'd7})
        begin
            tests_failed++;
            $display("FAIL m0_ar_fields: got seen=%0d id=%h addr=%h len=%h expected 1 0 bfc00000 7",
                     seen, axi_if.arid, axi_if.araddr, axi_if.arlen);
        end
        axi_if.arready = 1'b1;
        #1;
        tests_run++;
        if (m0_if.arready !== 1'b1 || m1_if.arready !== 1'b0) begin
            tests_failed++;
            $display("FAIL m0_arready_route: got m0=%b m1=%b expected 1 0",
                     m0_if.arready, m1_if.arready);
        end
        cyc();
        axi_if.arready = 1'b0;
        m0_if.arvalid = 1'b0;
        run_r_burst(8, 1'b0, 1'b1, bad);
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL m0_r_beats: got %0d bad beats expected 0", bad);
        end
        #1;
        tests_run++;
        if (dut.rd_state_q !== R_IDLE || axi_if.rready !== 1'b0) begin
            tests_failed++;
            $display("FAIL m0_idle_after_last: got state=%0d rready=%b expected 0 0",
                     dut.rd_state_q, axi_if.rready);
        end
    endtask

    task automatic test_two_masters();
        bit seen;
        int bad;
        apply_reset();
        m0_if.araddr = 32'h0000_1000; m0_if.arlen = 4'd3; m0_if.arvalid = 1'b1;
        m1_if.araddr = 32'h0000_2000; m1_if.arlen = 4'd3; m1_if.arvalid = 1'b1;
        wait_arvalid(seen);
        tests_run++;
        if (!seen || axi_if.arid !== 4'd0 || axi_if.araddr !== 32'h0000_1000) begin
            tests_failed++;
            $display("FAIL tie_first_grant: got seen=%0d id=%h addr=%h expected 1 0 1000",
                     seen, axi_if.arid, axi_if.araddr);
        end
        ar_handshake();
        m0_if.arvalid = 1'b0;
        run_r_burst(4, 1'b0, 1'b1, bad);
        #1;
        tests_run++;
        if (bad !== 0 || axi_if.arvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL tie_gap: got bad=%0d arvalid=%b expected 0 0", bad, axi_if.arvalid);
        end
        cyc();
        tests_run++;
        if (axi_if.arvalid !== 1'b1 || axi_if.arid !== 4'd1 || axi_if.araddr !== 32'h0000_2000)
        begin
            tests_failed++;
            $display("FAIL tie_second_grant: got vld=%b id=%h addr=%h expected 1 1 2000",
                     axi_if.arvalid, axi_if.arid, axi_if.araddr);
        end
        ar_handshake();
        m1_if.arvalid = 1'b0;
        run_r_burst(4, 1'b1, 1'b1, bad);
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL m1_r_beats: got %0d bad beats expected 0", bad);
        end
    endtask

    task automatic test_round_robin();
        bit          seen;
        int          bad;
        bit          exp_m1 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [3:0]  exp_id;
        apply_reset();
        m0_if.araddr = 32'h0000_a000; m0_if.arlen = 4'd1; m0_if.arvalid = 1'b1;
        m1_if.araddr = 32'h0000_b000; m1_if.arlen = 4'd1; m1_if.arvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_id = exp_m1[k] ? 4'd1 : 4'd0;
            wait_arvalid(seen);
            tests_run++;
            if (!seen || axi_if.arid !== exp_id) begin
                tests_failed++;
                $display("FAIL rr_grant_%0d: got seen=%0d id=%h expected 1 %h",
                         k, seen, axi_if.arid, exp_id);
            end
            ar_handshake();
            run_r_burst(2, exp_m1[k], 1'b1, bad);
            tests_run++;
            if (bad !== 0) begin
                tests_failed++;
                $display("FAIL rr_route_%0d: got %0d bad beats expected 0", k, bad);
            end
        end
        m0_if.arvalid = 1'b0;
        m1_if.arvalid = 1'b0;
    endtask

    task automatic test_raw_ordering();
        bit          seen;
        int          bad;
        int          early;
        int          wbad;
        logic [31:0] exp_w;
        apply_reset();
        early = 0;
        wbad  = 0;
        m1_if.awaddr = 32'h0000_3000; m1_if.awlen = 4'd7; m1_if.awvalid = 1'b1;
        cyc();
        m1_if.araddr = 32'h0000_4000; m1_if.arlen = 4'd1; m1_if.arvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (axi_if.arvalid !== 1'b0) early++;
            cyc();
        end
        tests_run++;
        if ({axi_if.awvalid, axi_if.awid, axi_if.awaddr, axi_if.awlen} !==
            {1'b1, 4'd1, 32'h0000_3000, 4'd7}) begin
            tests_failed++;
            $display("FAIL raw_aw_fields: got vld=%b id=%h addr=%h len=%h expected 1 1 3000 7",
                     axi_if.awvalid, axi_if.awid, axi_if.awaddr, axi_if.awlen);
        end
        axi_if.awready = 1'b1;
        #1;
        tests_run++;
        if (m1_if.awready !== 1'b1) begin
            tests_failed++;
            $display("FAIL raw_awready: got %b expected 1", m1_if.awready);
        end
        cyc();
        axi_if.awready = 1'b0;
        m1_if.awvalid = 1'b0;
        m0_if.araddr = 32'h0000_5000; m0_if.arlen = 4'd1; m0_if.arvalid = 1'b1;
        wait_arvalid(seen);
        tests_run++;
        if (!seen || axi_if.arid !== 4'd0 || axi_if.araddr !== 32'h0000_5000) begin
            tests_failed++;
            $display("FAIL raw_m0_during_write: got seen=%0d id=%h addr=%h expected 1 0 5000",
                     seen, axi_if.arid, axi_if.araddr);
        end
        ar_handshake();
        m0_if.arvalid = 1'b0;
        run_r_burst(2, 1'b0, 1'b1, bad);
        for (int i = 0; i < 8; i++) begin
            exp_w = 32'hcafe_0000 + 32'(i);
            m1_if.wvalid = 1'b1; m1_if.wdata = exp_w; m1_if.wstrb = 4'hf;
            m1_if.wlast = (i == 7);
            axi_if.wready = 1'b1;
            #1;
            if (!(axi_if.wvalid === 1'b1 && axi_if.wdata === exp_w && axi_if.wid === 4'd1 &&
                  axi_if.wlast === (i == 7) && m1_if.wready === 1'b1)) wbad++;
            if (axi_if.arvalid !== 1'b0) early++;
            cyc();
        end
        m1_if.wvalid = 1'b0; m1_if.wlast = 1'b0; axi_if.wready = 1'b0;
        tests_run++;
        if (wbad !== 0 || bad !== 0) begin
            tests_failed++;
            $display("FAIL raw_w_beats: got wbad=%0d rbad=%0d expected 0 0", wbad, bad);
        end
        axi_if.bvalid = 1'b1;
        axi_if.bresp  = 2'b01;
        m1_if.bready  = 1'b1;
        #1;
        tests_run++;
        if ({m1_if.bvalid, m1_if.bresp, axi_if.bready, axi_if.wvalid} !== {1'b1, 2'b01, 1'b1, 1'b0})
        begin
            tests_failed++;
            $display("FAIL raw_b_pass: got bvalid=%b bresp=%b bready=%b wvalid=%b expected 1 01 1 0",
                     m1_if.bvalid, m1_if.bresp, axi_if.bready, axi_if.wvalid);
        end
        cyc();
        axi_if.bvalid = 1'b0;
        m1_if.bready  = 1'b0;
        #1;
        tests_run++;
        if (early !== 0 || axi_if.arvalid !== 1'b0 || axi_if.bready !== 1'b0) begin
            tests_failed++;
            $display("FAIL raw_m1_held: got early=%0d arvalid=%b bready=%b expected 0 0 0",
                     early, axi_if.arvalid, axi_if.bready);
        end
        cyc();
        tests_run++;
        if (axi_if.arvalid !== 1'b1 || axi_if.arid !== 4'd1 || axi_if.araddr !== 32'h0000_4000)
        begin
            tests_failed++;
            $display("FAIL raw_m1_release: got vld=%b id=%h addr=%h expected 1 1 4000",
                     axi_if.arvalid, axi_if.arid, axi_if.araddr);
        end
        ar_handshake();
        m1_if.arvalid = 1'b0;
        run_r_burst(2, 1'b1, 1'b1, bad);
    endtask

    task automatic test_arready_stall();
        bit seen;
        int bad;
        int stall_bad;
        apply_reset();
        stall_bad = 0;
        m0_if.araddr = 32'h0000_6000; m0_if.arlen = 4'd0; m0_if.arvalid = 1'b1;
        m1_if.araddr = 32'h0000_7000; m1_if.arlen = 4'd0; m1_if.arvalid = 1'b1;
        wait_arvalid(seen);
        for (int i = 0; i < 5; i++) begin
            if (!(axi_if.arvalid === 1'b1 && axi_if.araddr === 32'h0000_6000 &&
                  axi_if.arid === 4'd0 && m0_if.arready === 1'b0 &&
                  m1_if.arready === 1'b0)) stall_bad++;
            cyc();
        end
        tests_run++;
        if (!seen || stall_bad !== 0) begin
            tests_failed++;
            $display("FAIL ar_stall_hold: got seen=%0d bad_cycles=%0d expected 1 0",
                     seen, stall_bad);
        end
        ar_handshake();
        m0_if.arvalid = 1'b0;
        run_r_burst(1, 1'b0, 1'b1, bad);
        m1_if.arvalid = 1'b0;
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL ar_stall_burst: got %0d bad beats expected 0", bad);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit         seen;
        int         bad;
        logic [6:0] vld;
        apply_reset();
        m0_if.araddr = 32'h0000_8000; m0_if.arlen = 4'd7; m0_if.arvalid = 1'b1;
        wait_arvalid(seen);
        ar_handshake();
        m0_if.arvalid = 1'b0;
        run_r_burst(3, 1'b0, 1'b0, bad);
        axi_if.rvalid = 1'b1;
        axi_if.rdata  = 32'hd000_0003;
        #1;
        aresetn = 1'b0;
        #1;
        vld = {axi_if.arvalid, axi_if.rready, axi_if.awvalid, axi_if.wvalid,
               m0_if.rvalid, m1_if.rvalid, m1_if.bvalid};
        tests_run++;
        if (vld !== 7'h00 || dut.rd_state_q !== R_IDLE || bad !== 0) begin
            tests_failed++;
            $display("FAIL async_reset: got valids=%h state=%0d bad=%0d expected 00 0 0",
                     vld, dut.rd_state_q, bad);
        end
        axi_if.rvalid = 1'b0;
        cyc();
        aresetn = 1'b1;
        m1_if.araddr = 32'h0000_9000; m1_if.arlen = 4'd0; m1_if.arvalid = 1'b1;
        wait_arvalid(seen);
        tests_run++;
        if (!seen || axi_if.arid !== 4'd1 || axi_if.araddr !== 32'h0000_9000) begin
            tests_failed++;
            $display("FAIL post_reset_grant: got seen=%0d id=%h addr=%h expected 1 1 9000",
                     seen, axi_if.arid, axi_if.araddr);
        end
        ar_handshake();
        m1_if.arvalid = 1'b0;
        run_r_burst(1, 1'b1, 1'b1, bad);
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL post_reset_burst: got %0d bad beats expected 0", bad);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_m0_single();
        test_two_masters();
        test_round_robin();
        test_raw_ordering();
        test_arready_stall();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/axi_bus_arbiter.md
Name: axi_bus_arbiter

Overview:
Shares the single CPU AXI master port between the instruction-cache refill engine (M0, read-only) and the data-cache engine (M1, read/write). Read requests are arbitrated round-robin and held per burst; the write channel belongs to M1 only. The block also stalls M1 reads while an M1 write is outstanding, so a read can never overtake a write. It sits between the icache/dcache AXI engines and the top-level AXI interface.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width
ID_W, 4, AXI ID width
M0_ID, 4'd0, arid driven for M0 bursts
M1_ID, 4'd1, arid/awid driven for M1 bursts

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
m0_araddr/arlen/arsize/arburst/arvalid  in  ADDR_W/4/3/2/1  M0 read-address request
m0_arready  out  1  M0 AR accept
m0_rdata/rresp/rlast/rvalid  out  DATA_W/2/1/1  M0 read data
m0_rready  in  1  M0 read-data accept
m1_araddr/arlen/arsize/arburst/arvalid  in  ADDR_W/4/3/2/1  M1 read-address request
m1_arready  out  1  M1 AR accept
m1_rdata/rresp/rlast/rvalid  out  DATA_W/2/1/1  M1 read data
m1_rready  in  1  M1 read-data accept
m1_awaddr/awlen/awsize/awburst/awvalid  in  ADDR_W/4/3/2/1  M1 write address
m1_awready  out  1  M1 AW accept
m1_wdata/wstrb/wlast/wvalid  in  DATA_W/4/1/1  M1 write data
m1_wready  out  1  M1 W accept
m1_bresp/bvalid  out  2/1  M1 write response
m1_bready  in  1  M1 response accept
arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  ID_W/ADDR_W/4/3/2/2/4/3/1  AXI AR
arready  in  1  AXI AR accept
rid/rdata/rresp/rlast/rvalid  in  ID_W/DATA_W/2/1/1  AXI R
rready  out  1  AXI R accept
awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  ID_W/ADDR_W/4/3/2/2/4/3/1  AXI AW
awready  in  1  AXI AW accept
wid/wdata/wstrb/wlast/wvalid  out  ID_W/DATA_W/4/1/1  AXI W
wready  in  1  AXI W accept
bid/bresp/bvalid  in  ID_W/2/1  AXI B
bready  out  1  AXI B accept

Behaviour:
- Reset (aresetn low, async): read FSM=R_IDLE, write FSM=W_IDLE, rr_last=M1 (so M0 wins the first tie). All valids/readies out are 0; arlock/awlock=0, arcache/awcache=0, arprot/awprot=0 at all times.
- Read FSM states: R_IDLE, R_AR, R_DATA.
- R_IDLE: candidates are m0_arvalid, and m1_arvalid & !wr_busy. If only one is valid, grant it; if both, grant the one != rr_last. Grant registered; next state R_AR. No request -> stay.
- R_AR: arvalid=1; AR fields and arid (M0_ID/M1_ID) muxed from granted master; arready routed only to granted master's arready. On arvalid&arready -> R_DATA, rr_last <= grant.
- R_DATA: R channel routed to granted master only (other master's rvalid=0); rready = granted rready. On rvalid&rready&rlast -> R_IDLE. Minimum gap between bursts: 1 idle cycle. rid is ignored for routing (one outstanding read).
- Granted master's AR inputs must remain stable until arready (AXI rule); arbiter never revokes a grant mid-burst.
- Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP. wr_busy = state != W_IDLE.
- W_IDLE: m1_awvalid -> W_ADDR. W_ADDR: AW passes through (awid=M1_ID); on handshake -> W_DATA. W_DATA: W passes through (wid=M1_ID); on wvalid&wready&wlast -> W_RESP. W_RESP: B passes through; on bvalid&bready -> W_IDLE.
- Outside their phase: awvalid=wvalid=0, m1_awready=m1_wready=m1_bvalid=0, bready=0.
- RAW ordering: M1 read in R_IDLE is not granted while wr_busy; M1 read already granted proceeds while M1 write starts (caches issue these for different lines). M0 reads never blocked by writes.
- Reset mid-burst: FSMs return to idle immediately; no completion is signalled to any master.

Decomposition:
- Shared package axi_arb_pkg: enums rd_state_t {R_IDLE,R_AR,R_DATA}, wr_state_t {W_IDLE,W_ADDR,W_DATA,W_RESP}, master-select type, M0_ID/M1_ID constants, AXI burst/size constants.
- One sub-module natural: axi_rr_arb2 (2-way round-robin grant from req vector + rr_last); rest stays in one module.

Test Plan:
- Only M0 arvalid, araddr=0xbfc00000, arlen=7 -> arid=0, araddr forwarded; 8 beats delivered to m0 only, m1_rvalid stays 0; R_IDLE after rlast.
- M0 and M1 arvalid together after reset -> M0 granted first, M1 burst starts 1 cycle after M0 rlast handshake with arid=1.
- Both continuously requesting for 4 bursts -> grant sequence M0,M1,M0,M1.
- M1 write (awlen=7) then M1 read 1 cycle later -> arvalid for M1 not asserted until cycle after bvalid&bready; M0 read issued meanwhile is granted.
- arready held low 5 cycles during M0 R_AR -> araddr/arvalid stable, no switch to M1 despite m1_arvalid.
- aresetn pulsed low during R_DATA beat 3 -> all valids 0 asynchronously; after release, new M1 request granted normally.
